// File: rtl/mouse_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mouse_pkg
// Description : Shared PS/2 mouse command/response codes and the init
//               sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mouse_pkg;

  localparam logic [7:0] CMD_RESET  = 8'hFF;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [7:0] RSP_ACK    = 8'hFA;
  localparam logic [7:0] RSP_BAT_OK = 8'hAA;
  localparam logic [7:0] RSP_ID     = 8'h00;

  typedef enum logic [2:0] {
    S_RST_SEND = 3'd0,
    S_RST_ACK  = 3'd1,
    S_BAT      = 3'd2,
    S_ID       = 3'd3,
    S_EN_SEND  = 3'd4,
    S_EN_ACK   = 3'd5,
    S_STREAM   = 3'd6,
    S_FAIL     = 3'd7
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mouse_packet_framer.sv
`default_nettype none
// ============================================================================
// Module      : mouse_packet_framer
// Description : Frames streamed mouse bytes into 3-byte packets, using bit 3
//               of the status byte for sync and a gap timer to drop stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module mouse_packet_framer #(
  parameter int GAP_TIMEOUT = 1_000_000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       enable,
  input  logic [7:0] data,
  input  logic       data_en,
  output logic       packet_valid,
  output logic [7:0] packet_status,
  output logic [7:0] packet_dx,
  output logic [7:0] packet_dy
);

  localparam int            GW       = (GAP_TIMEOUT > 1) ? $clog2(GAP_TIMEOUT) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TIMEOUT - 1);

  logic [1:0]    idx;
  logic [7:0]    byte0;
  logic [7:0]    byte1;
  logic [GW-1:0] gap;

  // Byte index, gap timer and packet latches; a byte wins over a gap expiry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idx           <= 2'd0;
      byte0         <= 8'h00;
      byte1         <= 8'h00;
      gap           <= '0;
      packet_valid  <= 1'b0;
      packet_status <= 8'h00;
      packet_dx     <= 8'h00;
      packet_dy     <= 8'h00;
    end else begin
      packet_valid <= 1'b0;
      if (!enable) begin
        idx <= 2'd0;
        gap <= '0;
      end else if (data_en) begin
        gap <= '0;
        case (idx)
          2'd0: begin
            // Status byte always has bit 3 set; anything else is mid-packet.
            if (data[3]) begin
              byte0 <= data;
              idx   <= 2'd1;
            end
          end
          2'd1: begin
            byte1 <= data;
            idx   <= 2'd2;
          end
          default: begin
            packet_status <= byte0;
            packet_dx     <= byte1;
            packet_dy     <= data;
            packet_valid  <= 1'b1;
            idx           <= 2'd0;
          end
        endcase
      end else if (idx != 2'd0) begin
        if (gap == GAP_LAST) begin
          idx <= 2'd0;
          gap <= '0;
        end else begin
          gap <= gap + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mouse_init_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mouse_init_sequencer
// Description : Sends the PS/2 mouse power-on sequence (FF, F4), validates
//               every response, retries on errors, then frames the stream.
// Revision    : 1.0 - initial release
// ============================================================================
module mouse_init_sequencer
  import mouse_pkg::*;
#(
  parameter int RESP_TIMEOUT = 50_000_000,
  parameter int GAP_TIMEOUT  = 1_000_000,
  parameter int MAX_RETRIES  = 3
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  input  logic       command_was_sent,
  input  logic       error_communication_timed_out,
  output logic       send_command,
  output logic [7:0] command_to_send,
  output logic       packet_valid,
  output logic [7:0] packet_status,
  output logic [7:0] packet_dx,
  output logic [7:0] packet_dy,
  output logic       streaming,
  output logic       init_error,
  output logic [1:0] retry_count
);

  localparam logic [25:0] RESP_LIMIT  = 26'(RESP_TIMEOUT);
  localparam logic [1:0]  RETRY_LIMIT = 2'(MAX_RETRIES);

  state_t      state;
  state_t      next_state;
  logic [1:0]  retry_next;
  logic [25:0] timer;
  logic        wait_st;
  logic        fail_evt;
  logic [7:0]  expected;
  state_t      success_state;

  // State, retry counter and registered outputs derived from the next state.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state           <= S_RST_SEND;
      retry_count     <= 2'd0;
      send_command    <= 1'b0;
      command_to_send <= 8'h00;
      streaming       <= 1'b0;
      init_error      <= 1'b0;
    end else begin
      state       <= next_state;
      retry_count <= retry_next;
      // Request drops for one cycle after any handshake, even on a retry.
      send_command <= ((next_state == S_RST_SEND) || (next_state == S_EN_SEND))
                      && !command_was_sent && !error_communication_timed_out;
      if (next_state == S_RST_SEND) begin
        command_to_send <= CMD_RESET;
      end else if (next_state == S_EN_SEND) begin
        command_to_send <= CMD_ENABLE;
      end
      streaming  <= (next_state == S_STREAM);
      init_error <= (next_state == S_FAIL);
    end
  end

  // Response timer: runs only in wait states, restarts on entry, saturates.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      timer <= 26'd0;
    end else if (!wait_st || (next_state != state)) begin
      timer <= 26'd0;
    end else if (timer != RESP_LIMIT) begin
      timer <= timer + 26'd1;
    end
  end

  // Next-state logic: response checking, handshakes and retry decisions.
  always_comb begin
    next_state    = state;
    retry_next    = retry_count;
    fail_evt      = 1'b0;
    wait_st       = 1'b0;
    expected      = RSP_ACK;
    success_state = state;
    case (state)
      S_RST_ACK: begin wait_st = 1'b1; expected = RSP_ACK;    success_state = S_BAT;     end
      S_BAT:     begin wait_st = 1'b1; expected = RSP_BAT_OK; success_state = S_ID;      end
      S_ID:      begin wait_st = 1'b1; expected = RSP_ID;     success_state = S_EN_SEND; end
      S_EN_ACK:  begin wait_st = 1'b1; expected = RSP_ACK;    success_state = S_STREAM;  end
      default:   ;
    endcase

    case (state)
      S_RST_SEND: begin
        if (command_was_sent)                   next_state = S_RST_ACK;
        else if (error_communication_timed_out) fail_evt   = 1'b1;
      end
      S_EN_SEND: begin
        if (command_was_sent)                   next_state = S_EN_ACK;
        else if (error_communication_timed_out) fail_evt   = 1'b1;
      end
      S_RST_ACK, S_BAT, S_ID, S_EN_ACK: begin
        // A byte in the same cycle as the timeout takes precedence.
        if (received_data_en) begin
          if (received_data == expected) next_state = success_state;
          else                           fail_evt   = 1'b1;
        end else if (timer == RESP_LIMIT) begin
          fail_evt = 1'b1;
        end
      end
      default: ;
    endcase

    if (fail_evt) begin
      if (retry_count == RETRY_LIMIT) begin
        next_state = S_FAIL;
      end else begin
        retry_next = retry_count + 2'd1;
        next_state = S_RST_SEND;
      end
    end
  end

  mouse_packet_framer #(
    .GAP_TIMEOUT (GAP_TIMEOUT)
  ) u_framer (
    .clk           (CLOCK_50),
    .resetn        (resetn),
    .enable        (streaming),
    .data          (received_data),
    .data_en       (received_data_en),
    .packet_valid  (packet_valid),
    .packet_status (packet_status),
    .packet_dx     (packet_dx),
    .packet_dy     (packet_dy)
  );

endmodule
`default_nettype wire

// File: tb/tb_mouse_init_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mouse_init_sequencer
// Description : Self-checking bench for mouse_init_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mouse_init_sequencer;

  localparam int RESP_T = 100;
  localparam int GAP_T  = 40;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] received_data = 8'h00;
  logic       received_data_en = 1'b0;
  logic       command_was_sent = 1'b0;
  logic       error_communication_timed_out = 1'b0;
  logic       send_command;
  logic [7:0] command_to_send;
  logic       packet_valid;
  logic [7:0] packet_status, packet_dx, packet_dy;
  logic       streaming, init_error;
  logic [1:0] retry_count;

  int vectors = 0;
  int miscompares = 0;
  logic [23:0] pkt_q[$];

  always #5 clk = ~clk;

  mouse_init_sequencer #(
    .RESP_TIMEOUT (RESP_T),
    .GAP_TIMEOUT  (GAP_T),
    .MAX_RETRIES  (3)
  ) dut (
    .CLOCK_50                      (clk),
    .resetn                        (resetn),
    .received_data                 (received_data),
    .received_data_en              (received_data_en),
    .command_was_sent              (command_was_sent),
    .error_communication_timed_out (error_communication_timed_out),
    .send_command                  (send_command),
    .command_to_send               (command_to_send),
    .packet_valid                  (packet_valid),
    .packet_status                 (packet_status),
    .packet_dx                     (packet_dx),
    .packet_dy                     (packet_dy),
    .streaming                     (streaming),
    .init_error                    (init_error),
    .retry_count                   (retry_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Packet scoreboard: every packet_valid cycle pops one expected packet.
  always @(negedge clk) begin
    if (resetn && packet_valid) begin
      if (pkt_q.size() == 0) check("pkt_unexpected", pkt_q.size(), 1);
      else check("pkt", {8'h00, packet_status, packet_dx, packet_dy}, {8'h00, pkt_q.pop_front()});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    received_data    = b;
    received_data_en = 1'b1;
    tick();
    received_data_en = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] s, input logic [7:0] x, input logic [7:0] y);
    pkt_q.push_back({s, x, y});
    send_byte(s);
    send_byte(x);
    send_byte(y);
  endtask

  task automatic wait_cmd(input logic [7:0] exp, input string tag);
    int n = 0;
    while (!send_command && n < 300) begin
      tick();
      n++;
    end
    check({tag, "_req"}, {31'd0, send_command}, 1);
    check({tag, "_byte"}, {24'd0, command_to_send}, {24'd0, exp});
  endtask

  task automatic ack_cmd();
    command_was_sent = 1'b1;
    tick();
    command_was_sent = 1'b0;
    check("cmd_drop", {31'd0, send_command}, 0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    received_data_en = 1'b0;
    command_was_sent = 1'b0;
    error_communication_timed_out = 1'b0;
    tick();
    tick();
    check("rst_ctrl", {18'd0, send_command, command_to_send, streaming, init_error, retry_count}, 0);
    check("rst_pkt", {7'd0, packet_valid, packet_status, packet_dx, packet_dy}, 0);
    resetn = 1'b1;
    tick();
    check("rst_rise", {23'd0, send_command, command_to_send}, {23'd0, 1'b1, 8'hFF});
  endtask

  task automatic init_nominal();
    wait_cmd(8'hFF, "rst_cmd");
    ack_cmd();
    send_byte(8'hFA);
    send_byte(8'hAA);
    send_byte(8'h00);
    wait_cmd(8'hF4, "en_cmd");
    ack_cmd();
    send_byte(8'hFA);
    check("streaming", {31'd0, streaming}, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Nominal init, with a stray byte during the send state that must be ignored.
    do_reset();
    send_byte(8'hFE);
    check("send_ignore_retry", {30'd0, retry_count}, 0);
    check("send_ignore_req", {31'd0, send_command}, 1);
    init_nominal();
    check("nom_retry", {30'd0, retry_count}, 0);
    check("nom_err", {31'd0, init_error}, 0);

    // Bad BAT, then a transmit error on F4, then a clean sequence.
    do_reset();
    wait_cmd(8'hFF, "bb_cmd");
    ack_cmd();
    send_byte(8'hFA);
    send_byte(8'hFC);
    check("bb_retry", {30'd0, retry_count}, 1);
    check("bb_resend", {23'd0, send_command, command_to_send}, {23'd0, 1'b1, 8'hFF});
    wait_cmd(8'hFF, "bb_cmd2");
    ack_cmd();
    send_byte(8'hFA);
    send_byte(8'hAA);
    send_byte(8'h00);
    wait_cmd(8'hF4, "txe_cmd");
    error_communication_timed_out = 1'b1;
    tick();
    error_communication_timed_out = 1'b0;
    check("txe_drop", {31'd0, send_command}, 0);
    check("txe_retry", {30'd0, retry_count}, 2);
    init_nominal();
    check("bb_final_retry", {30'd0, retry_count}, 2);

    // Retry exhaustion through response timeouts.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wait_cmd(8'hFF, "ex_cmd");
      check("ex_retry", {30'd0, retry_count}, i[31:0]);
      ack_cmd();
    end
    n = 0;
    while (!init_error && n < 300) begin
      tick();
      n++;
    end
    check("ex_init_error", {31'd0, init_error}, 1);
    check("ex_retry_final", {30'd0, retry_count}, 3);
    repeat (200) tick();
    send_byte(8'hFA);
    check("ex_hold", {29'd0, send_command, init_error, streaming}, {29'd0, 3'b010});

    // Streaming: framing, resync, gap timeout, output hold.
    do_reset();
    init_nominal();
    send_pkt(8'h09, 8'h05, 8'hFE);
    tick();
    send_byte(8'h02);
    send_pkt(8'h08, 8'h01, 8'h02);
    tick();
    send_byte(8'h08);
    send_byte(8'h01);
    repeat (GAP_T + 1) tick();
    send_pkt(8'h18, 8'h03, 8'h04);
    repeat (5) tick();
    check("pkt_hold", {8'h00, packet_status, packet_dx, packet_dy}, {8'h00, 24'h180304});

    // Asynchronous reset mid-packet clears everything immediately.
    send_byte(8'h08);
    send_byte(8'h01);
    resetn = 1'b0;
    #2;
    check("amid_ctrl", {18'd0, send_command, command_to_send, streaming, init_error, retry_count}, 0);
    check("amid_pkt", {7'd0, packet_valid, packet_status, packet_dx, packet_dy}, 0);
    tick();
    do_reset();
    init_nominal();
    send_pkt(8'h28, 8'h07, 8'h09);

    repeat (5) tick();
    check("pkt_q_empty", pkt_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mouse_init_sequencer.md
# mouse_init_sequencer

Sequences the PS/2 mouse that sits behind `MousePS2_Controller`. After reset it sends the power-on command sequence (Reset `0xFF`, then Enable Data Reporting `0xF4`) and checks every response byte. It retries on timeouts or bad responses, and once the mouse is streaming it frames the received bytes into validated 3-byte movement packets. It sits between `MousePS2_Controller` and the packet decoder, replacing the raw `received_data_en` path into the decoder.

## Interface
- `RESP_TIMEOUT`, default 50_000_000: cycles to wait for any single response byte (1 s at 50 MHz).
- `GAP_TIMEOUT`, default 1_000_000: maximum cycles between bytes of one stream packet (20 ms).
- `MAX_RETRIES`, default 3: full-sequence restarts before declaring failure.
- `CLOCK_50` input 1: sole clock.
- `resetn` input 1: asynchronous, active-low reset.
- `received_data` input 8: byte from the PS/2 controller.
- `received_data_en` input 1: one-cycle strobe; `received_data` is valid this cycle.
- `command_was_sent` input 1: one-cycle strobe from the controller; the command byte was acknowledged on the wire.
- `error_communication_timed_out` input 1: one-cycle strobe; the controller's transmit failed.
- `send_command` output 1: level request to transmit.
- `command_to_send` output 8: byte to transmit; held stable while `send_command`=1.
- `packet_valid` output 1: one-cycle strobe; a complete packet is on the packet outputs.
- `packet_status`, `packet_dx`, `packet_dy` output 8 each: bytes 0/1/2 of the last packet; they hold until the next packet.
- `streaming` output 1: initialisation is complete.
- `init_error` output 1: retries are exhausted; sticky until reset.
- `retry_count` output 2: restarts performed so far.

## Operation
- States: `S_RST_SEND`, `S_RST_ACK`, `S_BAT`, `S_ID`, `S_EN_SEND`, `S_EN_ACK`, `S_STREAM`, `S_FAIL`. The reset state is `S_RST_SEND`.
- **`S_RST_SEND`**
  - Drive `send_command`=1 with `command_to_send`=`0xFF`.
  - On `command_was_sent`, go to `S_RST_ACK`.
  - On `error_communication_timed_out`, retry.
- **`S_RST_ACK`**: expect `0xFA`, then go to `S_BAT`.
- **`S_BAT`**: expect `0xAA` (self-test passed), then go to `S_ID`.
- **`S_ID`**: expect `0x00`, then go to `S_EN_SEND`.
- **`S_EN_SEND`**
  - Drive `send_command`=1 with `command_to_send`=`0xF4`.
  - On `command_was_sent`, go to `S_EN_ACK`.
  - On `error_communication_timed_out`, retry.
- **`S_EN_ACK`**: expect `0xFA`, then go to `S_STREAM`.
- **Retry**
  - A retry is triggered by any unexpected byte (including `0xFE` or `0xFC`) in a wait state, a response timeout, or a transmit error.
  - If `retry_count`==`MAX_RETRIES`, go to `S_FAIL`.
  - Otherwise increment `retry_count` and return to `S_RST_SEND`.
- **`S_FAIL`**
  - `init_error`=1 and `send_command`=0.
  - All incoming bytes are ignored until `resetn`.
- **`S_STREAM`**
  - `streaming`=1.
  - A 2-bit byte index counts 0..2.
  - At index 0, a byte is accepted only if bit 3 = 1; otherwise it is discarded to resynchronise.
  - At index 2, latch all three bytes and pulse `packet_valid`, then return to index 0.
- **Gap timeout**: if the index is non-zero and no byte arrives for `GAP_TIMEOUT` cycles, reset the index to 0 and drop the partial packet.
- `streaming` is not re-checked after it is reached. A mouse hot-plug is recovered only by `resetn`.
- **Counters**
  - Response timer: 26-bit, cleared on every state entry and on every accepted byte.
  - The timer saturates at its compare value; it does not wrap.

## Timing
- **Reset values**
  - `send_command`=0, `command_to_send`=`0x00`, `packet_valid`=0.
  - Packet bytes = `0x00`, `streaming`=0, `init_error`=0, `retry_count`=0.
  - The index and timers are 0.
- `send_command` rises in the first cycle after `resetn` deasserts. It falls in the cycle after `command_was_sent` or `error_communication_timed_out`.
- A response byte is evaluated in its `received_data_en` cycle; the state changes on the next edge.
- `packet_valid` is high exactly one cycle: the cycle after the `received_data_en` of byte 2. The packet outputs update on the same edge.
- **Simultaneous events**
  - A byte arriving in the same cycle that a timeout reaches its limit is processed as the byte; the timeout is ignored.
  - A `received_data_en` during a `*_SEND` state is ignored.
- Asserting `resetn` low mid-sequence or mid-packet returns everything to reset values immediately (asynchronously); the partial packet is discarded.

## Structure
- Shared package `mouse_pkg`:
  - Command and response constants: `CMD_RESET`=`0xFF`, `CMD_ENABLE`=`0xF4`, `RSP_ACK`=`0xFA`, `RSP_BAT_OK`=`0xAA`, `RSP_ID`=`0x00`.
  - The state enumeration.
- One sub-module, `mouse_packet_framer`: holds the `S_STREAM` byte index, bit-3 sync check, gap timer and packet latches.
  - It is enabled by `streaming`.
  - It drives `packet_valid` and the packet bytes.

## Test plan
- **Nominal init**: after `command_was_sent`, feed `FA`, `AA`, `00`; after the second `command_was_sent`, feed `FA` → `command_to_send` sequence is `FF` then `F4`, `streaming`=1, `retry_count`=0.
- **Bad BAT**: feed `FA`, `FC` → `retry_count`=1 and `send_command` re-asserts with `FF`. A clean sequence after that → `streaming`=1.
- **Retry exhaustion**: with `RESP_TIMEOUT`=100 and `MAX_RETRIES`=3, never respond → `init_error`=1 after 4 attempts, `send_command` stays 0.
- **Packet framing**: in streaming, feed `09`, `05`, `FE` → one `packet_valid` pulse with status=`09`, dx=`05`, dy=`FE`.
- **Resync**: in streaming, feed `02` (bit3=0), then `08`, `01`, `02` → exactly one packet: `08`/`01`/`02`.
- **Gap and reset**: feed `08`, `01`, wait `GAP_TIMEOUT`+1 cycles, then feed `18`, `03`, `04` → one packet `18`/`03`/`04`. Asserting `resetn`=0 mid-packet → all outputs return to reset values.
